// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode map, ALU encodings and the control bundle carried down the pipe.
// Consumed by ctrl_decode and pipe_ctrl_unit.
package pipe_ctrl_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'b000001;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b001100;
    localparam logic [5:0] OPC_SLT   = 6'b111000;
    localparam logic [5:0] OPC_SLL   = 6'b111010;
    localparam logic [5:0] OPC_ADDI  = 6'b101000;

    localparam logic [2:0] ALU_NOP   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_RTYPE = 3'b010;
    localparam logic [2:0] ALU_ADD   = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_SLL   = 3'b110;

    // mem_to_reg=1 picks the ALU result at writeback, 0 picks load data.
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       branch;
        logic       jump;
        logic [2:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Pure combinational opcode decoder: control bundle plus whether rt is a source.
// Undefined opcodes decode to BUBBLE.
module ctrl_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opcode,
    output ctrl_bundle_t     ctrl,
    output logic             uses_rt
);

    always_comb begin
        ctrl    = BUBBLE;
        uses_rt = 1'b0;
        case (opcode)
            OPC_W'(OPC_RTYPE), OPC_W'(OPC_SLT), OPC_W'(OPC_SLL): begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                uses_rt         = 1'b1;
                if (opcode == OPC_W'(OPC_SLT))
                    ctrl.alu_op = ALU_SLT;
                else if (opcode == OPC_W'(OPC_SLL))
                    ctrl.alu_op = ALU_SLL;
                else
                    ctrl.alu_op = ALU_RTYPE;
            end
            OPC_W'(OPC_LW): begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OPC_W'(OPC_SW): begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
                uses_rt        = 1'b1;
            end
            OPC_W'(OPC_BEQ): begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
                uses_rt     = 1'b1;
            end
            OPC_W'(OPC_J): begin
                ctrl.jump = 1'b1;
            end
            OPC_W'(OPC_ADDI): begin
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_op     = ALU_ADD;
            end
            default: begin
                ctrl    = BUBBLE;
                uses_rt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decode, ID/EX-EX/MEM-MEM/WB control registers, load-use
// and branch hazard handling, saturating event counters. Optional illegal-opcode
// pulse enabled by PIPE_CTRL_ILLEGAL_TRAP_EN.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int ALUOP_W = 3,
    parameter int RA_W    = 5,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [OPC_W-1:0]   id_opcode,
    input  logic [RA_W-1:0]    id_rs,
    input  logic [RA_W-1:0]    id_rt,
    input  logic [RA_W-1:0]    id_rd,
    input  logic               stall_ext,
    input  logic               branch_taken,
    output logic               hazard_stall,
    output logic               pc_src,
    output logic               flush,
    output logic               ex_reg_dst,
    output logic               ex_alu_src,
    output logic               ex_branch,
    output logic               ex_jump,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [RA_W-1:0]    ex_dest,
    output logic               mem_read,
    output logic               mem_write,
    output logic               wb_reg_write,
    output logic               wb_mem_to_reg,
    output logic [CNT_W-1:0]   hazard_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic               illegal_op
);

    ctrl_bundle_t dec_ctrl;
    ctrl_bundle_t id_ctrl;
    ctrl_bundle_t ex_ctrl;
    logic         dec_uses_rt;
    logic         mem_reg_write;
    logic         mem_mem_to_reg;
    logic         hazard_raw;
    logic         redirect;
    logic         insert_bubble;
    logic [RA_W-1:0] id_dest;

    ctrl_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode  (id_opcode),
        .ctrl    (dec_ctrl),
        .uses_rt (dec_uses_rt)
    );

    assign id_ctrl = id_valid ? dec_ctrl : BUBBLE;
    assign id_dest = !id_valid ? '0 : (dec_ctrl.reg_dst ? id_rd : id_rt);

    assign hazard_raw = ex_ctrl.mem_read & id_valid & (ex_dest != '0) &
                        ((ex_dest == id_rs) | (dec_uses_rt & (ex_dest == id_rt)));
    assign redirect   = (ex_ctrl.branch & branch_taken) | ex_ctrl.jump;

    // A redirect squashes whatever sits in ID, so a coincident load-use stall is moot.
    assign pc_src        = ~stall_ext & redirect;
    assign flush         = pc_src;
    assign hazard_stall  = ~stall_ext & ~redirect & hazard_raw;
    assign insert_bubble = pc_src | hazard_stall;

    assign ex_reg_dst = ex_ctrl.reg_dst;
    assign ex_alu_src = ex_ctrl.alu_src;
    assign ex_branch  = ex_ctrl.branch;
    assign ex_jump    = ex_ctrl.jump;
    assign ex_alu_op  = ALUOP_W'(ex_ctrl.alu_op);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl        <= BUBBLE;
            ex_dest        <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
            wb_reg_write   <= 1'b0;
            wb_mem_to_reg  <= 1'b0;
            hazard_cnt     <= '0;
            flush_cnt      <= '0;
        end else if (!stall_ext) begin
            ex_ctrl        <= insert_bubble ? BUBBLE : id_ctrl;
            ex_dest        <= insert_bubble ? '0 : id_dest;
            mem_read       <= ex_ctrl.mem_read;
            mem_write      <= ex_ctrl.mem_write;
            mem_reg_write  <= ex_ctrl.reg_write;
            mem_mem_to_reg <= ex_ctrl.mem_to_reg;
            wb_reg_write   <= mem_reg_write;
            wb_mem_to_reg  <= mem_mem_to_reg;
            if (hazard_stall && (hazard_cnt != '1))
                hazard_cnt <= hazard_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

`ifdef PIPE_CTRL_ILLEGAL_TRAP_EN
    // Every legal opcode sets at least one control bit, so an all-zero decode of a
    // valid instruction means the opcode is undefined.  Gated so it fires once,
    // on the edge that actually retires the instruction into ID/EX.
    logic illegal_next;
    assign illegal_next = id_valid & (dec_ctrl == BUBBLE) & ~stall_ext & ~insert_bubble;

    always_ff @(posedge clk) begin
        if (rst)
            illegal_op <= 1'b0;
        else
            illegal_op <= illegal_next;
    end
`else
    assign illegal_op = 1'b0;
`endif

endmodule
